// File: rtl/tape_in_decoder.sv
// tape_in_decoder
//
// Turns the 16-bit line-in word from the audio codec interface into the
// single tape-input bit read by the Vector-06C I/O port. The block runs in the
// codec clock domain. It tracks and removes the DC offset, slices the result
// with hysteresis and a hold-off, and flags whether a tape signal is present.
//
// Ports
//   iCLK_18_4   in   1  18.432 MHz codec clock, the only clock of the block
//   iRST_N      in   1  asynchronous active-low reset
//   iLRCK       in   1  codec LR clock, asynchronous, synchronized here
//   iSAMPLE     in  16  line-in sample, two's complement, stable after the
//                       LRCK falling edge
//   oSAMPLE_STB out  1  one-clock pulse per accepted sample
//   oTAPEIN     out  1  sliced tape bit, equals the comparator state
//                       (0 = LOW, 1 = HIGH)
//   oACTIVE     out  1  a transition happened within the last IDLE_SAMPLES
//   oDC         out 16  current DC estimate, signed
//
// Flow: oSAMPLE_STB is a valid-only strobe. There is no ready and no
// back-pressure; every LRCK falling edge yields exactly one strobe. Stage A
// runs in the strobe cycle and stage B in the cycle after it. Both finish
// long before the next strobe, which comes one LRCK period later.

module tape_in_decoder #(
    parameter int          DC_SHIFT     = 8,
    parameter logic [15:0] HYST         = 16'd512,
    parameter int          HOLDOFF      = 4,
    parameter int          IDLE_SAMPLES = 4800
) (
    input  logic        iCLK_18_4,
    input  logic        iRST_N,
    input  logic        iLRCK,
    input  logic [15:0] iSAMPLE,
    output logic        oSAMPLE_STB,
    output logic        oTAPEIN,
    output logic        oACTIVE,
    output logic [15:0] oDC
);

    localparam int                 ACC_W    = 16 + DC_SHIFT + 1;
    localparam logic        [3:0]  HOLD_LD  = HOLDOFF[3:0];
    localparam logic        [12:0] IDLE_MAX = IDLE_SAMPLES[12:0];
    localparam logic signed [16:0] HYST_P   = {1'b0, HYST};
    localparam logic signed [16:0] HYST_N   = -HYST_P;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_e;

    // LRCK synchronizer and strobe
    logic lrck_s1_q, lrck_s2_q, lrck_s3_q;
    logic stb_q;
    logic stage_b_q;

    // Datapath
    logic signed [15:0]      dc_q;
    logic signed [15:0]      x_q;
    logic signed [16:0]      diff_q;
    logic signed [ACC_W-1:0] acc_q;

    // Comparator FSM and activity tracking
    state_e      state_q;
    logic        tapein_q;
    logic [3:0]  holdoff_q;
    logic [12:0] idle_q;
    logic        active_q;

    // Stage A combinational terms
    logic signed [15:0]      dc_d;
    logic signed [16:0]      diff_d;
    logic signed [15:0]      x_d;
    logic signed [ACC_W-1:0] acc_d;

    // Stage B combinational terms
    logic signed [16:0] x_ext;
    logic               go_high;
    logic               go_low;
    logic               transition;
    logic [12:0]        idle_d;

    // The accumulator holds the DC estimate scaled by 2^DC_SHIFT, so the
    // arithmetic shift yields the estimate itself. The low 16 bits are
    // enough because the tracker never leaves the sample range.
    assign dc_d   = 16'(acc_q >>> DC_SHIFT);
    assign diff_d = {iSAMPLE[15], iSAMPLE} - {dc_d[15], dc_d};

    // Saturate the 17-bit difference into 16 bits. Overflow shows up as a
    // mismatch between the top two bits, and bit 16 gives the true sign.
    always_comb begin
        x_d = diff_d[15:0];
        if (diff_d[16] != diff_d[15]) begin
            x_d = diff_d[16] ? 16'sh8000 : 16'sh7FFF;
        end
    end

    // The tracker integrates the unsaturated difference, so the estimate
    // follows the true offset even when x is clipped.
    assign acc_d = acc_q + {{DC_SHIFT{diff_q[16]}}, diff_q};

    assign x_ext      = {x_q[15], x_q};
    assign go_high    = (state_q == ST_LOW)  && (x_ext > HYST_P) && (holdoff_q == 4'd0);
    assign go_low     = (state_q == ST_HIGH) && (x_ext < HYST_N) && (holdoff_q == 4'd0);
    assign transition = go_high || go_low;

    always_comb begin
        idle_d = idle_q;
        if (transition) begin
            idle_d = 13'd0;
        end else if (idle_q < IDLE_MAX) begin
            idle_d = idle_q + 13'd1;
        end
    end

    // Synchronizer, strobe and datapath registers
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_s3_q <= 1'b0;
            stb_q     <= 1'b0;
            stage_b_q <= 1'b0;
            dc_q      <= '0;
            x_q       <= '0;
            diff_q    <= '0;
            acc_q     <= '0;
        end else begin
            lrck_s1_q <= iLRCK;
            lrck_s2_q <= lrck_s1_q;
            lrck_s3_q <= lrck_s2_q;
            // Previous value high, current value low: falling edge.
            stb_q     <= lrck_s3_q & ~lrck_s2_q;
            stage_b_q <= stb_q;
            if (stb_q) begin
                dc_q   <= dc_d;
                x_q    <= x_d;
                diff_q <= diff_d;
            end
            if (stage_b_q) begin
                acc_q <= acc_d;
            end
        end
    end

    // Comparator FSM with hold-off and activity tracking, updated in stage B
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_LOW;
            tapein_q  <= 1'b0;
            holdoff_q <= 4'd0;
            idle_q    <= IDLE_MAX;
            active_q  <= 1'b0;
        end else if (stage_b_q) begin
            case (state_q)
                ST_LOW: begin
                    if (go_high) begin
                        state_q  <= ST_HIGH;
                        tapein_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (go_low) begin
                        state_q  <= ST_LOW;
                        tapein_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_LOW;
                    tapein_q <= 1'b0;
                end
            endcase
            if (transition) begin
                holdoff_q <= HOLD_LD;
            end else if (holdoff_q != 4'd0) begin
                holdoff_q <= holdoff_q - 4'd1;
            end
            idle_q   <= idle_d;
            active_q <= (idle_d < IDLE_MAX);
        end
    end

    assign oSAMPLE_STB = stb_q;
    assign oTAPEIN     = tapein_q;
    assign oACTIVE     = active_q;
    assign oDC         = dc_q;

endmodule

// File: tb/tb_tape_in_decoder.sv
// Testbench for tape_in_decoder. Each sample is sent through one LRCK period
// of eight clocks. The expected outputs come from a sample-level reference
// model that applies the decoder's rules with plain integer arithmetic.

module tb_tape_in_decoder;

    localparam int DC_SHIFT = 8;
    localparam int HYST     = 512;
    localparam int HOLDOFF  = 4;
    localparam int IDLE     = 4800;

    logic        clk;
    logic        rst_n;
    logic        lrck;
    logic [15:0] sample;
    logic        stb;
    logic        tapein;
    logic        active;
    logic [15:0] dc;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one update per sample
    longint m_acc;
    int     m_dc;
    int     m_x;
    int     m_ho;
    int     m_idle;
    int     m_trans;
    bit     m_tap;
    bit     m_act;

    logic [17:0] exp_q[$];

    tape_in_decoder dut (
        .iCLK_18_4  (clk),
        .iRST_N     (rst_n),
        .iLRCK      (lrck),
        .iSAMPLE    (sample),
        .oSAMPLE_STB(stb),
        .oTAPEIN    (tapein),
        .oACTIVE    (active),
        .oDC        (dc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_acc   = 0;
        m_dc    = 0;
        m_x     = 0;
        m_ho    = 0;
        m_idle  = IDLE;
        m_tap   = 1'b0;
        m_act   = 1'b0;
    endtask

    function automatic int model_dc_now();
        return int'(m_acc >>> DC_SHIFT);
    endfunction

    task automatic model_step(input int s);
        int diff;
        bit trans;
        m_dc  = int'(m_acc >>> DC_SHIFT);
        diff  = s - m_dc;
        m_x   = (diff > 32767) ? 32767 : ((diff < -32768) ? -32768 : diff);
        m_acc = m_acc + longint'(diff);
        trans = 1'b0;
        if (m_ho == 0) begin
            if (!m_tap && m_x > HYST) begin
                m_tap = 1'b1;
                trans = 1'b1;
            end else if (m_tap && m_x < -HYST) begin
                m_tap = 1'b0;
                trans = 1'b1;
            end
        end
        if (trans) begin
            m_ho   = HOLDOFF;
            m_idle = 0;
            m_trans++;
        end else begin
            if (m_ho > 0) m_ho--;
            if (m_idle < IDLE) m_idle++;
        end
        m_act = (m_idle < IDLE);
    endtask

    // ---------------- driver ----------------
    // One LRCK period: high for two clocks, falling edge, then six clocks low.
    // Reports how many strobes were seen and at which clock after the edge,
    // oDC one clock after the strobe and the slicer outputs two clocks after.
    task automatic drive_sample(input int s, output int stb_n, output int stb_at,
                                output logic [15:0] dc_o, output logic tap_o,
                                output logic act_o);
        lrck = 1'b1;
        repeat (2) @(negedge clk);
        sample = 16'(s);
        lrck   = 1'b0;
        stb_n  = 0;
        stb_at = -1;
        dc_o   = 'x;
        tap_o  = 1'bx;
        act_o  = 1'bx;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (stb === 1'b1) begin
                stb_n++;
                if (stb_at < 0) stb_at = i;
            end
            if (i == 3) dc_o = dc;
            if (i == 4) begin
                tap_o = tapein;
                act_o = active;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        lrck   = 1'b0;
        sample = 16'h1234;
        model_reset();
        m_trans = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stb, tapein, active, dc} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_hold: stb=%b tap=%b act=%b dc=%h, required all 0",
                         stb, tapein, active, dc);
            end
            if (i % 2 == 1) lrck = ~lrck;
        end
        lrck  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stb, tapein, active} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_release: stb=%b tap=%b act=%b, required 000",
                         stb, tapein, active);
            end
        end
    endtask

    task automatic test_dc_offset();
        int sn, sa, dut_tr, dcv;
        logic [15:0] d;
        logic t, a, prev_t;
        dut_tr = 0;
        prev_t = tapein;
        for (int n = 0; n < 4810; n++) begin
            model_step(1000);
            drive_sample(1000, sn, sa, d, t, a);
            n_checks++;
            if (sn !== 1 || sa !== 2) begin
                n_fail++;
                $display("FAIL dc_stb n=%0d: count=%0d pos=%0d, required 1 at 2", n, sn, sa);
            end
            n_checks++;
            if (d !== 16'(m_dc)) begin
                n_fail++;
                $display("FAIL dc_est n=%0d: got %0d, required %0d", n, $signed(d), m_dc);
            end
            n_checks++;
            if (t !== m_tap || a !== m_act) begin
                n_fail++;
                $display("FAIL dc_slice n=%0d: tap=%b act=%b, required tap=%b act=%b",
                         n, t, a, m_tap, m_act);
            end
            if (t !== prev_t) dut_tr++;
            prev_t = t;
            if (n == 0) begin
                n_checks++;
                if (t !== 1'b1 || a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dc_first_rise: tap=%b act=%b, required 1 1", t, a);
                end
            end
            if (n == 4095) begin
                dcv = int'($signed(d));
                n_checks++;
                if (dcv < 999 || dcv > 1001) begin
                    n_fail++;
                    $display("FAIL dc_converge: got %0d, required 1000 +/- 1", dcv);
                end
            end
            if (n == 4799 || n == 4800) begin
                n_checks++;
                if (a !== (n == 4799)) begin
                    n_fail++;
                    $display("FAIL dc_idle n=%0d: act=%b, required %b", n, a, (n == 4799));
                end
            end
        end
        n_checks++;
        if (dut_tr !== 1) begin
            n_fail++;
            $display("FAIL dc_transitions: got %0d, required 1", dut_tr);
        end
    endtask

    task automatic test_hysteresis();
        int offs[14]  = '{-512, -513, 0, 0, 0, 0, 0, 512, 513, 0, 0, 0, 0, 0};
        bit exp_t[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int sn, sa, s;
        logic [15:0] d;
        logic t, a;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 14; k++) begin
                s = model_dc_now() + offs[k];
                model_step(s);
                drive_sample(s, sn, sa, d, t, a);
                n_checks++;
                if (t !== exp_t[k]) begin
                    n_fail++;
                    $display("FAIL hyst r=%0d k=%0d off=%0d: tap=%b, required %b",
                             r, k, offs[k], t, exp_t[k]);
                end
                n_checks++;
                if (d !== 16'(m_dc) || a !== m_act || sn !== 1) begin
                    n_fail++;
                    $display("FAIL hyst_misc r=%0d k=%0d: dc=%0d act=%b stb=%0d, required dc=%0d act=%b stb=1",
                             r, k, $signed(d), a, sn, m_dc, m_act);
                end
            end
        end
    endtask

    task automatic test_square();
        int sn, sa, s, dut_tr, m0;
        logic [15:0] d;
        logic t, a, prev_t;
        dut_tr = 0;
        m0     = m_trans;
        prev_t = tapein;
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < 2; h++) begin
                for (int k = 0; k < 24; k++) begin
                    s = (h == 0) ? 4000 : -4000;
                    model_step(s);
                    drive_sample(s, sn, sa, d, t, a);
                    n_checks++;
                    if (t !== (h == 0) || t !== m_tap) begin
                        n_fail++;
                        $display("FAIL square p=%0d h=%0d k=%0d: tap=%b, required %b",
                                 p, h, k, t, (h == 0));
                    end
                    n_checks++;
                    if (d !== 16'(m_dc) || a !== 1'b1 || sa !== 2) begin
                        n_fail++;
                        $display("FAIL square_misc p=%0d h=%0d k=%0d: dc=%0d act=%b stb_pos=%0d, required dc=%0d act=1 stb_pos=2",
                                 p, h, k, $signed(d), a, sa, m_dc);
                    end
                    if (t !== prev_t) dut_tr++;
                    prev_t = t;
                end
            end
        end
        n_checks++;
        if (dut_tr !== m_trans - m0) begin
            n_fail++;
            $display("FAIL square_transitions: got %0d, required %0d", dut_tr, m_trans - m0);
        end
    endtask

    task automatic test_holdoff();
        int sn, sa, s, ntr, last;
        logic [15:0] d;
        logic t, a, prev_t;
        ntr    = 0;
        last   = -1;
        prev_t = tapein;
        for (int n = 0; n < 30; n++) begin
            s = (n % 2 == 0) ? 2000 : -2000;
            model_step(s);
            drive_sample(s, sn, sa, d, t, a);
            n_checks++;
            if (t !== m_tap || d !== 16'(m_dc) || a !== m_act) begin
                n_fail++;
                $display("FAIL holdoff n=%0d: tap=%b dc=%0d act=%b, required tap=%b dc=%0d act=%b",
                         n, t, $signed(d), a, m_tap, m_dc, m_act);
            end
            if (t !== prev_t) begin
                if (last >= 0) begin
                    n_checks++;
                    if (n - last !== HOLDOFF + 1) begin
                        n_fail++;
                        $display("FAIL holdoff_spacing n=%0d: spacing %0d, required %0d",
                                 n, n - last, HOLDOFF + 1);
                    end
                end
                last = n;
                ntr++;
            end
            prev_t = t;
        end
        n_checks++;
        if (ntr !== 6) begin
            n_fail++;
            $display("FAIL holdoff_count: got %0d, required 6", ntr);
        end
    endtask

    task automatic test_random();
        int sn, sa, s, amp, run;
        bit pos;
        logic [15:0] d;
        logic t, a;
        logic [17:0] e;
        int n;
        n = 0;
        while (n < 300) begin
            pos = $urandom_range(0, 1);
            amp = $urandom_range(200, 8000);
            run = $urandom_range(1, 12);
            for (int k = 0; k < run; k++) begin
                s = (pos ? amp : -amp) + $urandom_range(0, 600) - 300;
                model_step(s);
                exp_q.push_back({16'(m_dc), m_tap, m_act});
                drive_sample(s, sn, sa, d, t, a);
                e = exp_q.pop_front();
                n_checks++;
                if ({d, t, a} !== e || sn !== 1) begin
                    n_fail++;
                    $display("FAIL random n=%0d s=%0d: dc=%0d tap=%b act=%b stb=%0d, required dc=%0d tap=%b act=%b stb=1",
                             n, s, $signed(d), t, a, sn, $signed(e[17:2]), e[1], e[0]);
                end
                n++;
            end
        end
    endtask

    task automatic test_saturation();
        int sn, sa;
        logic [15:0] d;
        logic t, a;
        for (int n = 0; n < 1200; n++) begin
            model_step(-32000);
            drive_sample(-32000, sn, sa, d, t, a);
            n_checks++;
            if (t !== m_tap || d !== 16'(m_dc) || a !== m_act) begin
                n_fail++;
                $display("FAIL sat_settle n=%0d: tap=%b dc=%0d act=%b, required tap=%b dc=%0d act=%b",
                         n, t, $signed(d), a, m_tap, m_dc, m_act);
            end
        end
        for (int n = 0; n < 4; n++) begin
            model_step(32767);
            drive_sample(32767, sn, sa, d, t, a);
            n_checks++;
            if (t !== 1'b1 || m_x !== 32767 || d !== 16'(m_dc) || a !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_burst n=%0d: tap=%b dc=%0d act=%b, required tap=1 dc=%0d act=1",
                         n, t, $signed(d), a, m_dc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sn, sa;
        logic [15:0] d;
        logic t, a;
        // Start a sample and stop just after stage A, with stage B pending.
        lrck = 1'b1;
        repeat (2) @(negedge clk);
        sample = 16'sd32767;
        lrck   = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stb, tapein, active, dc} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid: stb=%b tap=%b act=%b dc=%h, required all 0",
                     stb, tapein, active, dc);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if ({stb, tapein, active, dc} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_mid_release i=%0d: stb=%b tap=%b act=%b dc=%h, required all 0",
                         i, stb, tapein, active, dc);
            end
        end
        model_step(32767);
        drive_sample(32767, sn, sa, d, t, a);
        n_checks++;
        if (sn !== 1 || sa !== 2 || d !== 16'd0 || t !== 1'b1 || a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_resume: stb=%0d@%0d dc=%0d tap=%b act=%b, required 1@2 dc=0 tap=1 act=1",
                     sn, sa, $signed(d), t, a);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_dc_offset();
        test_hysteresis();
        test_square();
        test_holdoff();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tape_in_decoder.md
# tape_in_decoder

Converts the 16-bit line-in word delivered by the audio codec interface into the single tape-input bit that the Vector-06C I/O port reads. It sits directly downstream of the codec interface, in the codec clock domain. Each new sample is qualified by the codec LRCK. The block removes the DC offset, slices the signal with hysteresis and a hold-off, and reports whether a tape signal is present.

## Interface
Parameters:
- DC_SHIFT, 8: DC tracker time constant, 2^DC_SHIFT samples.
- HYST, 16'd512: hysteresis threshold. Magnitude, compared against the DC-free sample.
- HOLDOFF, 4: minimum samples between output transitions (0..15).
- IDLE_SAMPLES, 4800: samples without a transition before oACTIVE drops (100 ms at 48 kHz). Counter is 13 bits.

Ports:
- iCLK_18_4, input, 1: 18.432 MHz codec clock. Single clock of the block.
- iRST_N, input, 1: asynchronous active-low reset.
- iLRCK, input, 1: codec LR clock. Asynchronous to the block; it is synchronized internally.
- iSAMPLE, input, 16: line-in sample, two's complement. Stable for at least 8 clocks after the LRCK falling edge.
- oSAMPLE_STB, output, 1: one-clock pulse per accepted sample.
- oTAPEIN, output, 1: sliced tape bit. 1 when the signal is above the upper threshold.
- oACTIVE, output, 1: 1 while transitions occurred within the last IDLE_SAMPLES samples.
- oDC, output, 16: current DC estimate, signed.

## Operation
- Reset value of every output and internal register is 0, with two exceptions:
  - the idle counter resets to IDLE_SAMPLES, so oACTIVE=0;
  - the FSM resets to LOW, so oTAPEIN=0.
- **LRCK sync:** two-flop synchronizer s1→s2, then a previous-value flop s3. oSAMPLE_STB = registered (s3 & ~s2), i.e. one pulse per LRCK falling edge.
- **Stage A (on stb):**
  - s = iSAMPLE; dc = acc >>> DC_SHIFT, arithmetic shift; oDC = dc.
  - x = s − dc, computed in 17 bits and saturated to [−32768, +32767]; x is registered.
- **Stage B (one clock after stb):**
  - Accumulator update: acc ← acc + s − dc. acc is signed, 16+DC_SHIFT+1 bits, and never wraps.
  - The comparator FSM is evaluated.
- **FSM states:**
  - LOW: if x > +HYST and holdoff = 0, go to HIGH, set oTAPEIN=1 and load holdoff=HOLDOFF.
  - HIGH: if x < −HYST and holdoff = 0, go to LOW, set oTAPEIN=0 and load holdoff=HOLDOFF.
  - Comparisons are strict. x = ±HYST exactly causes no transition.
  - In any stage-B cycle without a transition, holdoff decrements if it is non-zero.
- **Activity:**
  - On a transition, the idle counter ← 0.
  - Otherwise, on each stage-B cycle, idle counter ← idle counter + 1, saturating at IDLE_SAMPLES.
  - oACTIVE = (idle counter < IDLE_SAMPLES), registered.
- **Missed samples:** no back-pressure. Samples are simply taken every LRCK period (384 clocks). Stages A and B always complete between strobes.

## Timing
- **Input to strobe:** iLRCK falling edge sampled at clock k. oSAMPLE_STB is high during cycle k+3 only.
- **Sample capture:** iSAMPLE is captured at the end of the stb cycle, at most 8 clocks after the edge, which is within the stability guarantee.
- **Output latency:** oTAPEIN, oACTIVE and the idle counter change at the end of the cycle after stb, so they are visible 2 clocks after the stb pulse.
- **oDC:** updates in the stb cycle with the pre-update estimate.
- **Reset mid-operation:** asserting iRST_N low at any time forces the reset values immediately. This includes a pending stb or stage-B cycle. After release, the first stb needs a full LRCK falling edge: the synchronizer resets to 0, so a low LRCK at release produces no strobe.

## Test plan
- **Reset:** hold iRST_N low and toggle iLRCK → oTAPEIN=0, oACTIVE=0, oDC=0 and no oSAMPLE_STB. Release with iLRCK low → first stb appears only after the next falling edge, +3 clocks.
- **Square wave:** iSAMPLE = +4000/−4000 at 1 kHz (24 samples per half-period), HOLDOFF=4 → oTAPEIN follows the sign with 2-clock stb latency, 2000 transitions/s, oACTIVE=1 after the first transition.
- **DC offset:** constant iSAMPLE=+1000 for 4096 samples → oTAPEIN rises once on the first sample (x=1000 > 512), then stays high with no further transitions. oDC converges to within ±1 of 1000. oACTIVE falls 4800 samples after that transition.
- **Hysteresis edge:** alternating ±512 around the settled DC → no transition. ±513 → oTAPEIN toggles every half-period.
- **Hold-off:** samples alternating +2000/−2000 every sample → transitions occur only every 5th sample, HOLDOFF+1 spacing.
- **Saturation:** DC settled near −32000, then iSAMPLE=+32767 → x saturates to +32767 with no sign flip, and oTAPEIN=1. Assert iRST_N low mid-burst → all outputs return to reset values in the same cycle.
